router_input_buffer: RTL and testbench
======================================

// Module: router_input_buffer
// PURPOSE
//  Per-port input stage of the router, directly upstream of the allocator. Buffers link words in a
//  show-ahead FIFO and presents them to the allocator as req/data with a ready pop strobe.
//  req is raised only when a complete packet (tail word, MSB=1) is stored, so an allocator grant
//  never stalls mid-packet on an empty buffer. One instance feeds allocator input 0, another input 1.
// PARAMETERS
//  WIDTH   11  word width; bit WIDTH-1 is the tail flag, bits WIDTH-2:0 are payload
//  DEPTH    8  FIFO entries; power of 2, >= 2
//  CNT_W   $clog2(DEPTH+1)  derived; width of the occupancy/packet counters
// PORTS
//  clk           in   1      single clock; all state changes on posedge
//  reset_n       in   1      asynchronous, active-low reset
//  in_wr         in   1      link write strobe; in_data is captured on posedge when in_wr=1
//  in_data       in   WIDTH  link word
//  in_full       out  1      FIFO holds DEPTH words; writes are dropped while high
//  req           out  1      request to allocator (connects to req_0 or req_1)
//  data_out      out  WIDTH  FIFO head word, show-ahead (connects to data_in_0 or data_in_1)
//  ready         in   1      allocator pop strobe; head consumed on posedge when ready=1
//  count         out  CNT_W  words stored
//  pkt_count     out  CNT_W  complete packets stored (tail words in FIFO)
//  err_overflow  out  1      sticky: in_wr seen while in_full
//  err_underflow out  1      sticky: ready seen while count==0
// BEHAVIOUR
//  Reset (async, reset_n=0): wr/rd pointers, count and pkt_count = 0; in_full=0, req=0,
//   err_overflow=0, err_underflow=0; data_out = 0 while empty. Storage array is not reset.
//  Write: in_wr & !in_full -> store at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//   in_wr & in_full -> word dropped, err_overflow<=1. in_full is evaluated from the registered
//   count only; a same-cycle pop does not allow a write into a full FIFO.
//  Read: ready & count!=0 -> rd_ptr++ (wrap mod DEPTH). ready & count==0 -> no change,
//   err_underflow<=1.
//  count: +1 on accepted write, -1 on valid pop, unchanged when both happen in the same cycle.
//  pkt_count: +1 on accepted write with in_data[WIDTH-1]=1; -1 on valid pop with
//   data_out[WIDTH-1]=1; unchanged when both occur. It never exceeds count.
//  data_out = mem[rd_ptr] when count!=0, else 0. It is combinational from registered state.
//   Latency from a write into an empty FIFO to the word on data_out is 1 cycle.
//  req = (pkt_count!=0) | (count==DEPTH). It is combinational from registers only, with no path
//   from ready. The second term is the cut-through fallback: a packet longer than DEPTH requests
//   once the FIFO is full, so the buffer does not deadlock.
//  req stays high through a multi-word drain because the packet's tail is still stored. After the
//   tail is popped, req drops on the following cycle unless another complete packet remains.
//  The sticky errors clear only on reset. Reset mid-packet discards all stored words immediately,
//   and req falls asynchronously.
//  Word order is preserved. There is no reordering, no duplication, and no loss except overflow drops.
// TESTING
//  1. Reset, write 3 words 0x001,0x002,0x403 -> req=0 after 2 writes; req=1 the cycle after
//     0x403 is written; count=3, pkt_count=1.
//  2. From 1, ready held for 3 cycles -> data_out steps 0x001,0x002,0x403; count=0,
//     pkt_count=0, req=0 after the third pop; err_underflow stays 0.
//  3. Write 8 non-tail words (DEPTH=8) -> in_full=1, req=1 (fallback); 9th write -> dropped,
//     err_overflow=1, count stays 8.
//  4. With count=4 and pkt_count=1, drive in_wr(tail)+ready(non-tail head) in the same cycle ->
//     count=4, pkt_count=2; then pop head=tail while writing a tail -> pkt_count unchanged.
//  5. Pointer wrap: 20 single-word packets 0x400|i, with a pop every other cycle -> output order
//     0x400..0x413 is exact, and no errors are flagged.
//  6. Pulse reset_n low mid-drain (count=5) -> count, pkt_count, req, in_full and data_out go
//     to 0 without waiting for a clk edge; after release, a new packet flows normally.
//     Also drive ready with count==0 -> err_underflow=1.

Source files
------------

// File: rtl/router_input_buffer_if.sv
// Link-side and allocator-side signals of one router input port.
// slave is the buffer; master is whatever drives the link and the allocator pop.
interface router_input_buffer_if #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic             in_wr;
  logic [WIDTH-1:0] in_data;
  logic             in_full;
  logic             req;
  logic [WIDTH-1:0] data_out;
  logic             ready;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pkt_count;
  logic             err_overflow;
  logic             err_underflow;

  modport master (
    output in_wr, in_data, ready,
    input  in_full, req, data_out, count, pkt_count, err_overflow, err_underflow
  );

  modport slave (
    input  in_wr, in_data, ready,
    output in_full, req, data_out, count, pkt_count, err_overflow, err_underflow
  );
endinterface

// File: rtl/router_input_buffer.sv
// Show-ahead input FIFO that requests the allocator only once a whole packet (or a full buffer) is held.
// Write-to-data_out latency 1 cycle; writes while full are dropped and flagged, pops while empty are flagged.
module router_input_buffer #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic                  clk,
  input logic                  reset_n,
  router_input_buffer_if.slave port
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] pkt_q;
  logic             ovf_q;
  logic             unf_q;

  logic             empty;
  logic             full;
  logic             wr_acc;
  logic             rd_acc;
  logic             wr_tail;
  logic             rd_tail;
  logic [WIDTH-1:0] head;

  // full is taken from the registered count so a same-cycle pop never frees a slot for a write
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(DEPTH));
    head    = empty ? '0 : mem[rd_ptr];
    wr_acc  = port.in_wr & ~full;
    rd_acc  = port.ready & ~empty;
    wr_tail = wr_acc & port.in_data[WIDTH-1];
    rd_tail = rd_acc & head[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= port.in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      pkt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);

      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      case ({wr_tail, rd_tail})
        2'b10:   pkt_q <= pkt_q + CNT_W'(1);
        2'b01:   pkt_q <= pkt_q - CNT_W'(1);
        default: pkt_q <= pkt_q;
      endcase

      if (port.in_wr & full)  ovf_q <= 1'b1;
      if (port.ready & empty) unf_q <= 1'b1;
    end
  end

  // A full buffer with no tail requests anyway so an over-long packet can cut through
  assign port.req           = (pkt_q != '0) | full;
  assign port.data_out      = head;
  assign port.in_full       = full;
  assign port.count         = count_q;
  assign port.pkt_count     = pkt_q;
  assign port.err_overflow  = ovf_q;
  assign port.err_underflow = unf_q;
endmodule

// File: tb/tb_router_input_buffer.sv
// Directed stimulus with a queue scoreboard; a negedge monitor checks every popped head word.
module tb_router_input_buffer;
  localparam int WIDTH = 11;
  localparam int DEPTH = 8;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] q[$];
  logic             exp_ovf = 1'b0;
  logic             exp_unf = 1'b0;

  router_input_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) port ();

  router_input_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .port    (port)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the allocator pops, the head must match the oldest expected word
  initial begin
    logic [WIDTH-1:0] w;
    forever begin
      @(negedge clk);
      if (reset_n && port.ready) begin
        if (q.size() > 0) begin
          w = q.pop_front();
          chk("pop_data", 32'(port.data_out), 32'(w));
        end else begin
          chk("underflow_data", 32'(port.data_out), 32'h0);
          exp_unf = 1'b1;
        end
      end
    end
  end

  task automatic check_model();
    int p = 0;
    foreach (q[i]) if (q[i][WIDTH-1]) p++;
    chk("count",     32'(port.count),     32'(q.size()));
    chk("pkt_count", 32'(port.pkt_count), 32'(p));
    chk("req",       32'(port.req),       32'((p != 0) || (q.size() == DEPTH)));
    chk("in_full",   32'(port.in_full),   32'(q.size() == DEPTH));
    chk("data_out",  32'(port.data_out),  (q.size() == 0) ? 32'h0 : 32'(q[0]));
    chk("err_ovf",   32'(port.err_overflow),  32'(exp_ovf));
    chk("err_unf",   32'(port.err_underflow), 32'(exp_unf));
  endtask

  // One clock: drive at posedge+1, commit at the next posedge, check at posedge+1
  task automatic cyc(input logic wr, input logic [WIDTH-1:0] d, input logic rd);
    logic acc;
    port.in_wr   = wr;
    port.in_data = d;
    port.ready   = rd;
    acc = wr && (q.size() < DEPTH);
    if (wr && q.size() == DEPTH) exp_ovf = 1'b1;
    @(posedge clk);
    if (acc) q.push_back(d);
    #1;
    port.in_wr = 1'b0;
    port.ready = 1'b0;
    check_model();
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    cyc(1'b1, d, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, '0, 1'b1);
  endtask

  task automatic expect_state(input string name, input int c, input int p, input logic r);
    chk({name, "_count"}, 32'(port.count),     32'(c));
    chk({name, "_pkt"},   32'(port.pkt_count), 32'(p));
    chk({name, "_req"},   32'(port.req),       32'(r));
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear with no clock
  task automatic reset_pulse(input string name);
    port.in_wr = 1'b0;
    port.ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk({name, "_count"},    32'(port.count),         32'h0);
    chk({name, "_pkt"},      32'(port.pkt_count),     32'h0);
    chk({name, "_req"},      32'(port.req),           32'h0);
    chk({name, "_full"},     32'(port.in_full),       32'h0);
    chk({name, "_data"},     32'(port.data_out),      32'h0);
    chk({name, "_ovf"},      32'(port.err_overflow),  32'h0);
    chk({name, "_unf"},      32'(port.err_underflow), 32'h0);
    q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    port.in_wr   = 1'b0;
    port.in_data = '0;
    port.ready   = 1'b0;
    #3;
    chk("rst_count", 32'(port.count),     32'h0);
    chk("rst_req",   32'(port.req),       32'h0);
    chk("rst_data",  32'(port.data_out),  32'h0);
    chk("rst_full",  32'(port.in_full),   32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Packet becomes requestable only once its tail is stored
    wr(11'h001);
    wr(11'h002);
    expect_state("t1a", 2, 0, 1'b0);
    wr(11'h403);
    expect_state("t1b", 3, 1, 1'b1);

    // Multi-word drain keeps req up until the tail leaves
    pop();
    expect_state("t2a", 2, 1, 1'b1);
    pop();
    expect_state("t2b", 1, 1, 1'b1);
    pop();
    expect_state("t2c", 0, 0, 1'b0);
    chk("t2_unf", 32'(port.err_underflow), 32'h0);

    // Fill with non-tail words: fallback request, then an overflow drop
    for (int i = 0; i < DEPTH; i++) wr(11'(11'h010 + i));
    expect_state("t3a", 8, 0, 1'b1);
    chk("t3_full", 32'(port.in_full), 32'h1);
    wr(11'h0FF);
    expect_state("t3b", 8, 0, 1'b1);
    chk("t3_ovf", 32'(port.err_overflow), 32'h1);
    for (int i = 0; i < DEPTH; i++) pop();
    expect_state("t3c", 0, 0, 1'b0);

    // Simultaneous write and pop with different tail combinations
    wr(11'h001);
    wr(11'h002);
    wr(11'h403);
    wr(11'h004);
    expect_state("t4a", 4, 1, 1'b1);
    cyc(1'b1, 11'h405, 1'b1);
    expect_state("t4b", 4, 2, 1'b1);
    pop();
    expect_state("t4c", 3, 2, 1'b1);
    cyc(1'b1, 11'h406, 1'b1);
    expect_state("t4d", 3, 2, 1'b1);
    for (int i = 0; i < 3; i++) pop();
    expect_state("t4e", 0, 0, 1'b0);

    // Pointer wrap with single-word packets
    reset_pulse("t5rst");
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      wr(11'h400 | 11'(i));
      pop();
    end
    expect_state("t5", 0, 0, 1'b0);
    chk("t5_ovf", 32'(port.err_overflow),  32'h0);
    chk("t5_unf", 32'(port.err_underflow), 32'h0);

    // Reset mid-drain, then a fresh packet, then an underflow
    for (int i = 1; i <= 6; i++) wr(11'(i));
    wr(11'h407);
    pop();
    pop();
    expect_state("t6a", 5, 1, 1'b1);
    reset_pulse("t6rst");
    @(posedge clk);
    #1;
    wr(11'h011);
    wr(11'h412);
    expect_state("t6b", 2, 1, 1'b1);
    pop();
    pop();
    expect_state("t6c", 0, 0, 1'b0);
    pop();
    chk("t6_unf", 32'(port.err_underflow), 32'h1);
    chk("t6_ovf", 32'(port.err_overflow),  32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
